fetch_stage: RTL and testbench

- Instruction-fetch stage that directly feeds the IF/ID pipeline buffer.
- Holds the PC register and computes PC+4.
- Contains a loadable instruction memory with combinational read.
- Selects the next PC from sequential, branch and jump sources, with a stall input and a halt state machine.
- Outputs pc_plus4 and instr drive the IF/ID buffer's address and instruction inputs directly.

---
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+4, loadable imem with combinational read, halt FSM.
// pc is registered (1 cycle); pc_plus4/instr are combinational from pc; stall holds pc and fetch_count.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic                          jump,
    input  logic [31:0]                   jump_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic [31:0]                   instr,
    output logic                          halted,
    output logic [31:0]                   fetch_count
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, count_nxt;
    logic [31:0] raw_word;
    logic        is_halt_word;
    logic [31:0] imem [IMEM_DEPTH];

    // Upper PC bits beyond the memory depth are dropped, so addresses alias.
    assign raw_word     = imem[pc[AW+1:2]];
    assign is_halt_word = (raw_word == HALT_WORD);
    assign pc_plus4     = pc + 32'd4;
    assign instr        = (state == HALT) ? 32'h0 : raw_word;
    assign halted       = (state == HALT);

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = fetch_count;
        if (state == RUN && !stall) begin
            // The halt word is neither counted nor advanced past, even with a redirect pending.
            if (is_halt_word) begin
                state_nxt = HALT;
            end else begin
                count_nxt = fetch_count + 32'd1;
                if (jump) begin
                    pc_nxt = {jump_target[31:2], 2'b00};
                end else if (branch_taken) begin
                    pc_nxt = {branch_target[31:2], 2'b00};
                end else begin
                    pc_nxt = pc_plus4;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: halt sequence, stall, redirects, wrap/alias, write collision, async reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc, pc_plus4, instr, fetch_count;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(.IMEM_DEPTH(256), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; imem_we = 1'b0; imem_waddr = 8'h0; imem_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i < 3)       d = 32'h11 * (i + 1);
            else if (i == 3) d = 32'hFFFF_FFFF;
            else             d = 32'h1000 + i;
            imem_we = 1'b1; imem_waddr = i[7:0]; imem_wdata = d;
        end
        @(negedge clk);
        imem_we = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4 actual=%h required=%h", pc_plus4, 32'h4); end
        n_cmp++; if (instr !== 32'h11) begin n_err++; $display("FAIL reset_instr actual=%h required=%h", instr, 32'h11); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted actual=%b required=0", halted); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL reset_count actual=%0d required=0", fetch_count); end
    endtask

    task automatic test_stall();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h4 || instr !== 32'h22) begin n_err++; $display("FAIL run_pc4 actual=%h/%h required=4/22", pc, instr); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (pc !== 32'h4 || instr !== 32'h22 || fetch_count !== 32'd1) begin
                n_err++; $display("FAIL stall_hold%0d actual=%h/%h/%0d required=4/22/1", k, pc, instr, fetch_count); end
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h8 || instr !== 32'h33 || fetch_count !== 32'd2) begin
            n_err++; $display("FAIL stall_release actual=%h/%h/%0d required=8/33/2", pc, instr, fetch_count); end
    endtask

    task automatic test_halt();
        @(negedge clk);
        n_cmp++; if (pc !== 32'hC || instr !== 32'hFFFF_FFFF || halted !== 1'b0) begin
            n_err++; $display("FAIL halt_word_seen actual=%h/%h/%b required=c/ffffffff/0", pc, instr, halted); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (pc !== 32'hC || instr !== 32'h0 || halted !== 1'b1 || fetch_count !== 32'd3) begin
                n_err++; $display("FAIL halted%0d actual=%h/%h/%b/%0d required=c/0/1/3", k, pc, instr, halted, fetch_count); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'h0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            n_err++; $display("FAIL async_reset actual=%h/%b/%0d required=0/0/0", pc, halted, fetch_count); end
        n_cmp++; if (instr !== 32'h11) begin n_err++; $display("FAIL mem_retained actual=%h required=11", instr); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_redirect();
        @(negedge clk);
        @(negedge clk);
        jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h40 || instr !== 32'h1010) begin n_err++; $display("FAIL jump_wins actual=%h/%h required=40/1010", pc, instr); end
        jump = 1'b0; branch_target = 32'h23;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h20 || instr !== 32'h1008) begin n_err++; $display("FAIL branch_align actual=%h/%h required=20/1008", pc, instr); end
        branch_taken = 1'b0; stall = 1'b1; jump = 1'b1; jump_target = 32'h60;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL stall_over_jump actual=%h required=20", pc); end
        stall = 1'b0;
        @(negedge clk);
        jump = 1'b0;
        n_cmp++; if (pc !== 32'h60 || fetch_count !== 32'd5) begin n_err++; $display("FAIL held_jump actual=%h/%0d required=60/5", pc, fetch_count); end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        @(negedge clk);
        jump = 1'b0;
        n_cmp++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instr !== 32'h10FF) begin
            n_err++; $display("FAIL top_pc actual=%h/%h/%h required=fffffffc/0/10ff", pc, pc_plus4, instr); end
        @(negedge clk);
        n_cmp++; if (pc !== 32'h0 || instr !== 32'h11) begin n_err++; $display("FAIL pc_wrap actual=%h/%h required=0/11", pc, instr); end
        jump = 1'b1; jump_target = 32'h400;
        @(negedge clk);
        n_cmp++; if (pc !== 32'h400 || instr !== 32'h11) begin n_err++; $display("FAIL alias actual=%h/%h required=400/11", pc, instr); end
        jump_target = 32'h407;
        @(negedge clk);
        jump = 1'b0;
        n_cmp++; if (pc !== 32'h404 || instr !== 32'h22) begin n_err++; $display("FAIL alias_align actual=%h/%h required=404/22", pc, instr); end
    endtask

    task automatic test_collision();
        jump = 1'b1; jump_target = 32'h4;
        @(negedge clk);
        jump = 1'b0; stall = 1'b1;
        imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hAB;
        #1;
        n_cmp++; if (instr !== 32'h22) begin n_err++; $display("FAIL collide_before actual=%h required=22", instr); end
        @(negedge clk);
        imem_we = 1'b0; stall = 1'b0;
        #1;
        n_cmp++; if (pc !== 32'h4 || instr !== 32'hAB) begin n_err++; $display("FAIL collide_after actual=%h/%h required=4/ab", pc, instr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_halt();
        test_async_reset();
        test_redirect();
        test_wrap();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
